// File: rtl/spike_pkt_pkg.sv
// Shared constants, packet field layout and FSM encoding for the spike packetizer.
package spike_pkt_pkg;

   localparam int DEF_NUM_OUTPUTS = 250;
   localparam int DEF_IDX_W       = 8;
   localparam int DEF_FRAME_W     = 15;
   localparam int DEF_FIFO_DEPTH  = 16;

   // pkt_data layout: {eof, frame_no, neuron_idx}
   localparam int PKT_W     = 1 + DEF_FRAME_W + DEF_IDX_W;
   localparam int EOF_BIT   = PKT_W - 1;
   localparam int FRAME_LSB = DEF_IDX_W;
   localparam int IDX_LSB   = 0;

   localparam logic [DEF_IDX_W-1:0] NO_SPIKE_IDX = '1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

endpackage

// File: rtl/spike_packetizer_if.sv
// Frame-in / packet-out handshake bundle of the spike packetizer.
interface spike_packetizer_if #(
   parameter int NUM_OUTPUTS = spike_pkt_pkg::DEF_NUM_OUTPUTS,
   parameter int PW          = spike_pkt_pkg::PKT_W
);
   // A transfer happens on a rising clk edge where valid and ready are both 1;
   // a source holds valid and its payload stable until that edge, and ready
   // may change freely while valid is low.
   logic                   frame_valid;
   logic                   frame_ready;
   logic [NUM_OUTPUTS-1:0] frame_spikes;
   logic                   pkt_valid;
   logic                   pkt_ready;
   logic [PW-1:0]          pkt_data;

   modport master (
      output frame_valid, frame_spikes, pkt_ready,
      input  frame_ready, pkt_valid, pkt_data
   );

   modport slave (
      input  frame_valid, frame_spikes, pkt_ready,
      output frame_ready, pkt_valid, pkt_data
   );
endinterface

// File: rtl/spike_pkt_fifo.sv
// Synchronous FIFO without fall-through; the head entry is read from storage flops.
module spike_pkt_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] rdata
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   // Push only looks at the registered full flag, so a same-cycle pop never makes room.
   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/spike_packetizer.sv
// Turns each per-tick output spike vector into {eof, frame_no, neuron_idx} packets,
// lowest neuron index first, one packet per cycle into a small output FIFO.
module spike_packetizer
   import spike_pkt_pkg::*;
#(
   parameter int NUM_OUTPUTS = DEF_NUM_OUTPUTS,
   parameter int IDX_W       = DEF_IDX_W,
   parameter int FRAME_W     = DEF_FRAME_W,
   parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
   input  logic               clk,
   input  logic               reset,
   spike_packetizer_if.slave  bus,
   output logic               busy,
   output logic [FRAME_W-1:0] frame_count,
   output state_t             state_dbg
);
   localparam int POS_W = $clog2(NUM_OUTPUTS);
   localparam int PW    = 1 + FRAME_W + IDX_W;

   // Bit b holds neuron NUM_OUTPUTS-1-b, so the highest set bit is the lowest index.
   function automatic logic [POS_W-1:0] top_bit(input logic [NUM_OUTPUTS-1:0] v);
      top_bit = '0;
      for (int b = 0; b < NUM_OUTPUTS; b++)
         if (v[b]) top_bit = POS_W'(b);
   endfunction

   state_t                 state_q, state_d;
   logic [NUM_OUTPUTS-1:0] shadow_q;
   logic [NUM_OUTPUTS-1:0] shadow_cleared;
   logic [FRAME_W-1:0]     frame_no_q;
   logic [FRAME_W-1:0]     frame_cnt_q;
   logic [POS_W-1:0]       hit_pos;
   logic [IDX_W-1:0]       hit_idx;
   logic                   pkt_eof;
   logic                   accept;
   logic                   push;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [PW-1:0]          push_data;
   logic [PW-1:0]          fifo_rdata;

   // An empty shadow yields hit_pos 0 and a zero cleared vector, i.e. the eof-only packet.
   always_comb begin
      hit_pos        = top_bit(shadow_q);
      shadow_cleared = shadow_q & ~({{(NUM_OUTPUTS-1){1'b0}}, 1'b1} << hit_pos);
      pkt_eof        = ~|shadow_cleared;
      hit_idx        = (|shadow_q) ? IDX_W'(NUM_OUTPUTS - 1 - int'(hit_pos)) : NO_SPIKE_IDX;
      push_data      = {pkt_eof, frame_no_q, hit_idx};
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.frame_valid) state_d = ST_SCAN;
         ST_SCAN: if (push && pkt_eof) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.frame_ready = (state_q == ST_IDLE);
      accept          = (state_q == ST_IDLE) & bus.frame_valid;
      push            = (state_q == ST_SCAN) & ~fifo_full;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_q    <= '0;
         frame_no_q  <= '0;
         frame_cnt_q <= '0;
      end else if (accept) begin
         shadow_q    <= bus.frame_spikes;
         frame_no_q  <= frame_cnt_q;
         frame_cnt_q <= frame_cnt_q + FRAME_W'(1);
      end else if (push) begin
         shadow_q    <= shadow_cleared;
      end
   end

   spike_pkt_fifo #(
      .WIDTH (PW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (push_data),
      .pop   (bus.pkt_ready),
      .full  (fifo_full),
      .empty (fifo_empty),
      .rdata (fifo_rdata)
   );

   assign bus.pkt_valid = ~fifo_empty;
   assign bus.pkt_data  = fifo_rdata;
   assign busy          = (state_q != ST_IDLE) | ~fifo_empty;
   assign frame_count   = frame_cnt_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_spike_packetizer.sv
// Directed and randomized checks of spike_packetizer against a per-frame packet list model.
module tb_spike_packetizer;
   import spike_pkt_pkg::*;

   localparam int NO = DEF_NUM_OUTPUTS;
   localparam int FW = DEF_FRAME_W;
   localparam int IW = DEF_IDX_W;
   localparam int PW = 1 + FW + IW;

   logic          clk = 1'b0;
   logic          reset;
   logic          busy;
   logic [FW-1:0] frame_count;
   state_t        state_dbg;

   spike_packetizer_if #(.NUM_OUTPUTS(NO), .PW(PW)) bus ();

   spike_packetizer dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .busy        (busy),
      .frame_count (frame_count),
      .state_dbg   (state_dbg)
   );

   always #5 clk = ~clk;

   logic [PW-1:0] exp_q[$];
   int            n_checks    = 0;
   int            n_errors    = 0;
   int            cyc         = 0;
   int            n_pops      = 0;
   int            n_not_ready = 0;
   logic [FW-1:0] model_cnt;
   logic          accepted;
   logic          hold_valid;
   logic          rand_ready;
   logic [PW-1:0] hold_data;
   logic [PW-1:0] last_pkt;
   logic [PW-1:0] prev_pkt;
   logic [NO-1:0] v;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
      n_checks++;
      assert (obs === req) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
      end
   endtask

   function automatic logic [PW-1:0] mk_pkt(input logic eof, input logic [FW-1:0] fno,
                                            input logic [IW-1:0] idx);
      logic [PW-1:0] p;
      p = '0;
      p[EOF_BIT]         = eof;
      p[FRAME_LSB +: FW] = fno;
      p[IDX_LSB +: IW]   = idx;
      return p;
   endfunction

   // Packets a frame must produce: every set neuron in ascending index order.
   task automatic model_frame(input logic [NO-1:0] vec, input logic [FW-1:0] fno);
      int last;
      last = -1;
      for (int i = 0; i < NO; i++) if (vec[NO-1-i]) last = i;
      if (last < 0) exp_q.push_back(mk_pkt(1'b1, fno, NO_SPIKE_IDX));
      else
         for (int i = 0; i <= last; i++)
            if (vec[NO-1-i]) exp_q.push_back(mk_pkt(i == last, fno, IW'(i)));
   endtask

   task automatic observe();
      if (hold_valid) begin
         check("pkt_hold_valid", bus.pkt_valid, 1);
         check("pkt_hold_data", bus.pkt_data, hold_data);
      end
      hold_valid = bus.pkt_valid & ~bus.pkt_ready;
      hold_data  = bus.pkt_data;
      if (bus.pkt_valid && bus.pkt_ready) begin
         check("pkt_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) check("pkt_data", bus.pkt_data, exp_q.pop_front());
         prev_pkt = last_pkt;
         last_pkt = bus.pkt_data;
         n_pops++;
      end
      if (!bus.frame_ready) n_not_ready++;
      accepted = bus.frame_valid & bus.frame_ready;
      if (accepted) begin
         model_frame(bus.frame_spikes, model_cnt);
         model_cnt++;
      end
   endtask

   task automatic cycle();
      if (rand_ready) bus.pkt_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (!reset) observe();
      else accepted = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset(input int n);
      reset           = 1'b1;
      bus.frame_valid = 1'b0;
      bus.pkt_ready   = 1'b0;
      rand_ready      = 1'b0;
      repeat (n) cycle();
      reset      = 1'b0;
      exp_q.delete();
      model_cnt  = '0;
      hold_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [NO-1:0] vec);
      int guard;
      guard            = 0;
      bus.frame_valid  = 1'b1;
      bus.frame_spikes = vec;
      do begin
         cycle();
         guard++;
      end while (!accepted && guard < 5000);
      check("frame_accept", accepted, 1);
      bus.frame_valid = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard         = 0;
      rand_ready    = 1'b0;
      bus.pkt_ready = 1'b1;
      while ((exp_q.size() != 0 || bus.pkt_valid || busy) && guard < 3000) begin
         cycle();
         guard++;
      end
      check("drain_busy", busy, 0);
      check("drain_queue", exp_q.size(), 0);
   endtask

   initial begin
      int pops_before;
      int guard;
      int mode;
      reset            = 1'b1;
      bus.frame_valid  = 1'b0;
      bus.frame_spikes = '0;
      bus.pkt_ready    = 1'b0;
      rand_ready       = 1'b0;
      hold_valid       = 1'b0;
      accepted         = 1'b0;
      model_cnt        = '0;
      last_pkt         = '0;
      prev_pkt         = '0;
      @(posedge clk);
      #1;
      do_reset(2);

      // reset values
      check("rst_frame_ready", bus.frame_ready, 1);
      check("rst_pkt_valid", bus.pkt_valid, 0);
      check("rst_pkt_data", bus.pkt_data, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_count", frame_count, 0);
      check("rst_state", state_dbg, ST_IDLE);

      // neurons 0 and 249, first packet latency
      v = '0;
      v[NO-1] = 1'b1;
      v[0]    = 1'b1;
      bus.pkt_ready = 1'b1;
      send_frame(v);
      check("t1_frame_count", frame_count, 1);
      check("t1_valid_t1", bus.pkt_valid, 0);
      check("t1_busy", busy, 1);
      cycle();
      check("t1_valid_t2", bus.pkt_valid, 1);
      check("t1_first_pkt", bus.pkt_data, mk_pkt(1'b0, 0, 0));
      drain();
      check("t1_last_pkt", last_pkt, mk_pkt(1'b1, 0, 249));

      // empty frame
      do_reset(1);
      bus.pkt_ready = 1'b1;
      pops_before = n_pops;
      send_frame('0);
      check("t2_state_t1", state_dbg, ST_SCAN);
      check("t2_ready_t1", bus.frame_ready, 0);
      cycle();
      check("t2_state_t2", state_dbg, ST_IDLE);
      check("t2_pkt", bus.pkt_data, mk_pkt(1'b1, 0, NO_SPIKE_IDX));
      drain();
      check("t2_pkt_count", n_pops - pops_before, 1);

      // all neurons, consumer stalled until the FIFO backs up the scan
      do_reset(1);
      v = '1;
      pops_before = n_pops;
      send_frame(v);
      repeat (30) cycle();
      check("t3_stall_state", state_dbg, ST_SCAN);
      check("t3_stall_ready", bus.frame_ready, 0);
      check("t3_stall_valid", bus.pkt_valid, 1);
      check("t3_stall_head", bus.pkt_data, mk_pkt(1'b0, 0, 0));
      drain();
      check("t3_pkt_count", n_pops - pops_before, 250);
      check("t3_last_pkt", last_pkt, mk_pkt(1'b1, 0, 249));

      // back-to-back single-spike frames
      do_reset(1);
      bus.pkt_ready = 1'b1;
      n_not_ready = 0;
      for (int k = 5; k <= 7; k++) begin
         v = '0;
         v[NO-1-k] = 1'b1;
         send_frame(v);
      end
      drain();
      check("t4_not_ready_cycles", n_not_ready, 3);
      check("t4_last_pkt", last_pkt, mk_pkt(1'b1, 2, 7));
      check("t4_frame_count", frame_count, 3);

      // reset in the middle of a 10-spike scan
      do_reset(1);
      bus.pkt_ready = 1'b1;
      v = '0;
      for (int k = 10; k < 20; k++) v[NO-1-k] = 1'b1;
      send_frame(v);
      pops_before = n_pops;
      guard = 0;
      while (n_pops - pops_before < 3 && guard < 100) begin
         cycle();
         guard++;
      end
      check("t5_three_pops", n_pops - pops_before, 3);
      do_reset(1);
      check("t5_pkt_valid", bus.pkt_valid, 0);
      check("t5_frame_count", frame_count, 0);
      check("t5_frame_ready", bus.frame_ready, 1);
      check("t5_busy", busy, 0);
      bus.pkt_ready = 1'b1;
      v = '0;
      v[NO-1-42] = 1'b1;
      pops_before = n_pops;
      send_frame(v);
      drain();
      check("t5_pkt_count", n_pops - pops_before, 1);
      check("t5_new_pkt", last_pkt, mk_pkt(1'b1, 0, 42));

      // frame counter wrap
      do_reset(1);
      bus.pkt_ready    = 1'b1;
      bus.frame_valid  = 1'b1;
      bus.frame_spikes = '0;
      guard = 0;
      while (model_cnt != '1 && guard < 70000) begin
         cycle();
         guard++;
      end
      bus.frame_valid = 1'b0;
      drain();
      check("t6_count_max", frame_count, 15'h7fff);
      v = '0;
      v[NO-1-3] = 1'b1;
      send_frame(v);
      send_frame(v);
      check("t6_count_wrapped", frame_count, 1);
      drain();
      check("t6_pkt_max", prev_pkt, mk_pkt(1'b1, 15'h7fff, 3));
      check("t6_pkt_wrap", last_pkt, mk_pkt(1'b1, 0, 3));

      // random frames with a randomly stalling consumer
      do_reset(1);
      rand_ready = 1'b1;
      for (int f = 0; f < 40; f++) begin
         mode = $urandom_range(0, 3);
         v = '0;
         case (mode)
            0: ;
            1: repeat ($urandom_range(1, 5)) v[$urandom_range(0, NO-1)] = 1'b1;
            2: for (int b = 0; b < NO; b++) v[b] = 1'($urandom_range(0, 1));
            default: v[$urandom_range(0, NO-1)] = 1'b1;
         endcase
         repeat ($urandom_range(0, 2)) cycle();
         send_frame(v);
      end
      drain();
      check("t7_frame_count", frame_count, 40);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
